// File: rtl/fb_shared_tapline_if.sv
// fb_shared_tapline_if: control, sample and tap-bus signals of the shared tap line.
// Lane width follows FB_TAPLINE_SYMFOLD_EN (DATA_W+1 with symmetric pre-add, else DATA_W).
interface fb_shared_tapline_if #(
    parameter int DATA_W = 14,
    parameter int TAPS   = 119,
    parameter int PHASES = 60,
    parameter int LANES  = 2
);
    localparam int PH_W = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam int TB_W = (TAPS > 1) ? $clog2(TAPS) : 1;
`ifdef FB_TAPLINE_SYMFOLD_EN
    localparam int LANE_W = DATA_W + 1;
`else
    localparam int LANE_W = DATA_W;
`endif

    logic                      clk_enable;
    logic                      flush;
    logic signed [DATA_W-1:0]  filter_in;
    logic [PH_W-1:0]           phase;
    logic                      shift_pulse;
    logic [TAPS*DATA_W-1:0]    taps_flat;
    logic                      tap_valid;
    logic [TB_W-1:0]           tap_base;
    logic                      tap_first;
    logic                      tap_last;
    logic [LANES*LANE_W-1:0]   tap_lanes;

    modport master (
        output clk_enable, flush, filter_in,
        input  phase, shift_pulse, taps_flat, tap_valid, tap_base,
               tap_first, tap_last, tap_lanes
    );

    modport slave (
        input  clk_enable, flush, filter_in,
        output phase, shift_pulse, taps_flat, tap_valid, tap_base,
               tap_first, tap_last, tap_lanes
    );
endinterface

// File: rtl/fb_shared_tapline.sv
// fb_shared_tapline: shared input delay line for the non-uniform filterbank.
// A free-running phase counter shifts one sample per frame (PHASES cycles) on a
// clock enable; taps are exposed in parallel and swept serially LANES per beat.
// Build macro FB_TAPLINE_SYMFOLD_EN: the sweep carries symmetric pre-added pairs
// line[f] + line[TAPS-1-f] (centre tap alone for odd TAPS), one bit wider.
module fb_shared_tapline #(
    parameter int DATA_W = 14,
    parameter int TAPS   = 119,
    parameter int PHASES = 60,
    parameter int LANES  = 2
) (
    input  logic               clock,
    input  logic               reset,
    fb_shared_tapline_if.slave bus
);
    localparam int PH_W = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam int TB_W = (TAPS > 1) ? $clog2(TAPS) : 1;
`ifdef FB_TAPLINE_SYMFOLD_EN
    localparam int LANE_W = DATA_W + 1;
    localparam int NFOLD  = (TAPS + 1) / 2;
    localparam int NSWEEP = (NFOLD + LANES - 1) / LANES;
`else
    localparam int LANE_W = DATA_W;
    localparam int NSWEEP = (TAPS + LANES - 1) / LANES;
`endif
    localparam int NBEAT_TAPS = NSWEEP * LANES;

    if (NSWEEP > PHASES) begin : g_bad_cfg
        $error("fb_shared_tapline: sweep needs more beats than PHASES provides");
    end

    logic signed [DATA_W-1:0] line_q [TAPS];
    logic signed [DATA_W-1:0] line_d [TAPS];
    logic [PH_W-1:0]          phase_q, phase_d;
    logic                     pulse_q, pulse_d;
    logic                     shift;

    // Sweep source values, padded to a whole number of beats.
    logic [LANE_W-1:0]        pre [NBEAT_TAPS];
    logic [TAPS*DATA_W-1:0]   taps_w;
    logic [LANES*LANE_W-1:0]  lanes_w;
    logic [TB_W-1:0]          base_w;
    logic                     hit_w, first_w, last_w, sweep_en;

    assign shift = bus.clk_enable && (phase_q == PH_W'(PHASES - 1));

    // Next-state: phase advance, shift pulse, and line shift or flush.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves a latch.
        phase_d = phase_q;
        pulse_d = pulse_q;
        line_d  = line_q;
        if (bus.clk_enable) begin
            pulse_d = shift;
            phase_d = shift ? '0 : phase_q + PH_W'(1);
        end
        if (bus.flush) begin
            for (int k = 0; k < TAPS; k++) line_d[k] = '0;
        end else if (shift) begin
            line_d[0] = bus.filter_in;
            for (int k = 1; k < TAPS; k++) line_d[k] = line_q[k-1];
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q <= '0;
            pulse_q <= 1'b0;
            // NOTE: the line is a flop array (every tap is visible in parallel), so it is reset, not left as RAM.
            for (int k = 0; k < TAPS; k++) line_q[k] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            phase_q <= phase_d;
            pulse_q <= pulse_d;
            line_q  <= line_d;
        end
    end

    // Per-beat lane sources; out-of-range indices are never elaborated.
    for (genvar i = 0; i < NBEAT_TAPS; i++) begin : g_pre
`ifdef FB_TAPLINE_SYMFOLD_EN
        if (i >= NFOLD) begin : g_pad
            assign pre[i] = '0;
        end else if ((TAPS % 2 == 1) && (i == (TAPS - 1) / 2)) begin : g_centre
            assign pre[i] = {line_q[i][DATA_W-1], line_q[i]};
        end else begin : g_pair
            assign pre[i] = {line_q[i][DATA_W-1], line_q[i]}
                          + {line_q[TAPS-1-i][DATA_W-1], line_q[TAPS-1-i]};
        end
`else
        if (i >= TAPS) begin : g_pad
            assign pre[i] = '0;
        end else begin : g_tap
            assign pre[i] = line_q[i];
        end
`endif
    end

    // Parallel view of the delay line, tap 0 in the low bits.
    always_comb begin
        taps_w = '0;
        for (int k = 0; k < TAPS; k++) taps_w[k*DATA_W +: DATA_W] = line_q[k];
    end

    assign sweep_en = bus.clk_enable & ~reset;

    // Serial sweep: pick the beat addressed by the phase; everything is zero when idle.
    always_comb begin
        hit_w   = 1'b0;
        first_w = 1'b0;
        last_w  = 1'b0;
        base_w  = '0;
        lanes_w = '0;
        if (sweep_en) begin
            for (int b = 0; b < NSWEEP; b++) begin
                if (phase_q == PH_W'(b)) begin
                    hit_w   = 1'b1;
                    first_w = (b == 0);
                    last_w  = (b == NSWEEP - 1);
                    base_w  = TB_W'(b * LANES);
                    for (int j = 0; j < LANES; j++) begin
                        lanes_w[j*LANE_W +: LANE_W] = pre[b*LANES + j];
                    end
                end
            end
        end
    end

    assign bus.phase       = phase_q;
    assign bus.shift_pulse = pulse_q;
    assign bus.taps_flat   = taps_w;
    assign bus.tap_valid   = hit_w;
    assign bus.tap_base    = base_w;
    assign bus.tap_first   = first_w;
    assign bus.tap_last    = last_w;
    assign bus.tap_lanes   = lanes_w;
endmodule
